// File: rtl/temporal_encoder.sv
// Temporal (race-logic) encoder: turns an operand pair into spike edges or pulses
// within a fixed-length gamma cycle, with a one-deep pending buffer for back-to-back pairs.
module temporal_encoder #(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  parameter  int PULSE_WIDTH       = 8,
  parameter  int PULSE_MODE        = 0,
  localparam int VW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] val_a,
  input  logic [VW-1:0] val_b,
  output logic          out_a,
  output logic          out_b,
  output logic          gamma_rst,
  output logic          gamma_start,
  output logic [VW-1:0] gamma_slot
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [VW-1:0] SLOT_LAST = VW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VW:0]   LAST_LIVE = (VW+1)'(GAMMA_CYCLE_WIDTH - 2);
  localparam logic [VW:0]   PW        = (VW+1)'(PULSE_WIDTH);

  state_t        state_q, state_d;
  logic [VW-1:0] slot_q, slot_d;
  logic [VW-1:0] act_a_q, act_a_d, act_b_q, act_b_d;
  logic [VW-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic          pend_valid_q, pend_valid_d;
  logic          out_a_q, out_a_d, out_b_q, out_b_d;
  logic          gamma_rst_q, gamma_rst_d;
  logic          gamma_start_q, gamma_start_d;
  logic          xfer;

  assign in_ready = ~pend_valid_q;
  assign xfer     = in_valid & ~pend_valid_q;

  // Channel level for a given (state, value, slot); values >= G-1 never fire
  // because the live window ends at slot G-2.
  function automatic logic chan_on(input state_t st, input logic [VW-1:0] act,
                                   input logic [VW-1:0] slot);
    logic [VW:0] act_x;
    logic [VW:0] slot_x;
    logic        on;
    act_x  = {1'b0, act};
    slot_x = {1'b0, slot};
    on     = (st == RUN) && (act_x <= slot_x) && (slot_x <= LAST_LIVE);
    if (PULSE_MODE != 0) on = on && (slot_x < act_x + PW);
    return on;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    slot_d       = slot_q;
    act_a_d      = act_a_q;
    act_b_d      = act_b_q;
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;
    pend_valid_d = pend_valid_q;

    unique case (state_q)
      IDLE: begin
        slot_d = '0;
        if (xfer) begin
          act_a_d = val_a;
          act_b_d = val_b;
          state_d = RUN;
        end
      end
      RUN: begin
        if (slot_q != SLOT_LAST) begin
          slot_d = slot_q + VW'(1);
          if (xfer) begin
            pend_a_d     = val_a;
            pend_b_d     = val_b;
            pend_valid_d = 1'b1;
          end
        end else if (pend_valid_q) begin
          act_a_d      = pend_a_q;
          act_b_d      = pend_b_q;
          pend_valid_d = 1'b0;
          slot_d       = '0;
        end else if (xfer) begin
          // A pair arriving in the reset slot starts the next cycle with no idle gap.
          act_a_d = val_a;
          act_b_d = val_b;
          slot_d  = '0;
        end else begin
          state_d = IDLE;
          slot_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase

    // Outputs are computed from next state so the flops present glitch-free levels.
    out_a_d       = chan_on(state_d, act_a_d, slot_d);
    out_b_d       = chan_on(state_d, act_b_d, slot_d);
    gamma_rst_d   = (state_d == IDLE) || (slot_d == SLOT_LAST);
    gamma_start_d = (state_d == RUN) && (slot_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      act_a_q       <= '0;
      act_b_q       <= '0;
      pend_a_q      <= '0;
      pend_b_q      <= '0;
      pend_valid_q  <= 1'b0;
      out_a_q       <= 1'b0;
      out_b_q       <= 1'b0;
      gamma_rst_q   <= 1'b1;
      gamma_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      act_a_q       <= act_a_d;
      act_b_q       <= act_b_d;
      pend_a_q      <= pend_a_d;
      pend_b_q      <= pend_b_d;
      pend_valid_q  <= pend_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      gamma_rst_q   <= gamma_rst_d;
      gamma_start_q <= gamma_start_d;
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign gamma_rst   = gamma_rst_q;
  assign gamma_start = gamma_start_q;
  assign gamma_slot  = slot_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Bench for temporal_encoder: rising-mode and pulse-mode instances share stimulus;
// directed scenarios plus a randomized run against a queue-based reference model.
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int PW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [VW-1:0] val_a, val_b;

  logic          r_ready, r_a, r_b, r_grst, r_gstart;
  logic [VW-1:0] r_slot;
  logic          p_ready, p_a, p_b, p_grst, p_gstart;
  logic [VW-1:0] p_slot;

  // Observed status, packed as {in_ready, out_a, out_b, gamma_rst, gamma_start, gamma_slot}.
  logic [8:0] r_obs, p_obs;
  assign r_obs = {r_ready, r_a, r_b, r_grst, r_gstart, r_slot};
  assign p_obs = {p_ready, p_a, p_b, p_grst, p_gstart, p_slot};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .PULSE_MODE(0)) dut_rise (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_ready),
    .val_a(val_a), .val_b(val_b), .out_a(r_a), .out_b(r_b),
    .gamma_rst(r_grst), .gamma_start(r_gstart), .gamma_slot(r_slot)
  );

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .PULSE_MODE(1)) dut_pulse (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_ready),
    .val_a(val_a), .val_b(val_b), .out_a(p_a), .out_b(p_b),
    .gamma_rst(p_grst), .gamma_start(p_gstart), .gamma_slot(p_slot)
  );

  // Expected channel level at slot s for spike time act.
  function automatic bit on(int s, int act, bit pulse);
    return (act <= s) && (s <= G - 2) && (!pulse || (s < act + PW));
  endfunction

  function automatic logic [8:0] vec(bit rdy, bit a, bit b, bit grst, bit gstart, int slot);
    return {rdy, a, b, grst, gstart, 4'(slot)};
  endfunction

  // Reference model: a queue of accepted pairs (front = active, second = pending).
  bit m_run  = 1'b0;
  int m_slot = 0;
  int qa[$];
  int qb[$];

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && !rst && (qa.size() < 2);
    if (rst) begin
      m_run = 1'b0; m_slot = 0; qa.delete(); qb.delete();
    end else if (!m_run) begin
      if (acc) begin
        qa.push_back(int'(val_a)); qb.push_back(int'(val_b)); m_run = 1'b1; m_slot = 0;
      end
    end else if (m_slot < G - 1) begin
      m_slot++;
      if (acc) begin qa.push_back(int'(val_a)); qb.push_back(int'(val_b)); end
    end else begin
      void'(qa.pop_front()); void'(qb.pop_front());
      if (acc) begin qa.push_back(int'(val_a)); qb.push_back(int'(val_b)); end
      m_slot = 0;
      if (qa.size() == 0) m_run = 1'b0;
    end
  end

  task automatic test_reset();
    logic [8:0] e;
    rst = 1'b1; in_valid = 1'b1; val_a = 4'd3; val_b = 4'd5;
    repeat (2) @(negedge clk);
    e = vec(1, 0, 0, 1, 0, 0);
    checks += 2;
    if (r_obs !== e) begin errors++; $display("FAIL reset_rise: got %h expected %h", r_obs, e); end
    if (p_obs !== e) begin errors++; $display("FAIL reset_pulse: got %h expected %h", p_obs, e); end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks += 1;
    if (r_obs !== e) begin errors++; $display("FAIL reset_no_xfer: got %h expected %h", r_obs, e); end
  endtask

  task automatic test_rising();
    logic [8:0] e_r, e_p;
    in_valid = 1'b1; val_a = 4'd3; val_b = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < G; s++) begin
      e_r = vec(1, on(s, 3, 0), on(s, 5, 0), s == G - 1, s == 0, s);
      e_p = vec(1, on(s, 3, 1), on(s, 5, 1), s == G - 1, s == 0, s);
      checks += 2;
      if (r_obs !== e_r) begin errors++; $display("FAIL rising_rise slot %0d: got %h expected %h", s, r_obs, e_r); end
      if (p_obs !== e_p) begin errors++; $display("FAIL rising_pulse slot %0d: got %h expected %h", s, p_obs, e_p); end
      @(negedge clk);
    end
    e_r = vec(1, 0, 0, 1, 0, 0);
    checks += 1;
    if (r_obs !== e_r) begin errors++; $display("FAIL rising_idle: got %h expected %h", r_obs, e_r); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e_r, e_p;
    in_valid = 1'b1; val_a = 4'd2; val_b = 4'd2;
    @(negedge clk);
    for (int s = 0; s < G; s++) begin
      e_r = vec(s == 0, on(s, 2, 0), on(s, 2, 0), s == G - 1, s == 0, s);
      e_p = vec(s == 0, on(s, 2, 1), on(s, 2, 1), s == G - 1, s == 0, s);
      checks += 3;
      if (r_obs !== e_r) begin errors++; $display("FAIL b2b_first_rise slot %0d: got %h expected %h", s, r_obs, e_r); end
      if (p_obs !== e_p) begin errors++; $display("FAIL b2b_first_pulse slot %0d: got %h expected %h", s, p_obs, e_p); end
      if (r_a !== r_b) begin errors++; $display("FAIL b2b_equal slot %0d: got a=%b b=%b expected equal", s, r_a, r_b); end
      if (s == 0) begin val_a = 4'd7; val_b = 4'd15; end
      if (s == 1) in_valid = 1'b0;
      @(negedge clk);
    end
    for (int s = 0; s < G; s++) begin
      e_r = vec(1, on(s, 7, 0), 0, s == G - 1, s == 0, s);
      e_p = vec(1, on(s, 7, 1), 0, s == G - 1, s == 0, s);
      checks += 2;
      if (r_obs !== e_r) begin errors++; $display("FAIL b2b_second_rise slot %0d: got %h expected %h", s, r_obs, e_r); end
      if (p_obs !== e_p) begin errors++; $display("FAIL b2b_second_pulse slot %0d: got %h expected %h", s, p_obs, e_p); end
      @(negedge clk);
    end
    e_r = vec(1, 0, 0, 1, 0, 0);
    checks += 1;
    if (r_obs !== e_r) begin errors++; $display("FAIL b2b_idle: got %h expected %h", r_obs, e_r); end
  endtask

  task automatic test_pulse();
    logic [8:0] e_r, e_p;
    in_valid = 1'b1; val_a = 4'd10; val_b = 4'd0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < G; s++) begin
      e_r = vec(1, on(s, 10, 0), on(s, 0, 0), s == G - 1, s == 0, s);
      e_p = vec(1, (s >= 10) && (s <= 14), s <= 7, s == G - 1, s == 0, s);
      checks += 2;
      if (r_obs !== e_r) begin errors++; $display("FAIL pulse_rise slot %0d: got %h expected %h", s, r_obs, e_r); end
      if (p_obs !== e_p) begin errors++; $display("FAIL pulse_pulse slot %0d: got %h expected %h", s, p_obs, e_p); end
      @(negedge clk);
    end
  endtask

  task automatic test_coincident();
    logic [8:0] e_r, e_p;
    in_valid = 1'b1; val_a = 4'd1; val_b = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < G; s++) begin
      e_r = vec(1, on(s, 1, 0), on(s, 4, 0), s == G - 1, s == 0, s);
      checks += 1;
      if (r_obs !== e_r) begin errors++; $display("FAIL coinc_first slot %0d: got %h expected %h", s, r_obs, e_r); end
      if (s == G - 1) begin in_valid = 1'b1; val_a = 4'd6; val_b = 4'd9; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int s = 0; s < G; s++) begin
      e_r = vec(1, on(s, 6, 0), on(s, 9, 0), s == G - 1, s == 0, s);
      e_p = vec(1, on(s, 6, 1), on(s, 9, 1), s == G - 1, s == 0, s);
      checks += 2;
      if (r_obs !== e_r) begin errors++; $display("FAIL coinc_second_rise slot %0d: got %h expected %h", s, r_obs, e_r); end
      if (p_obs !== e_p) begin errors++; $display("FAIL coinc_second_pulse slot %0d: got %h expected %h", s, p_obs, e_p); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e_r;
    in_valid = 1'b1; val_a = 4'd2; val_b = 4'd3;
    @(negedge clk);
    for (int s = 0; s <= 6; s++) begin
      e_r = vec(s == 0, on(s, 2, 0), on(s, 3, 0), 0, s == 0, s);
      checks += 1;
      if (r_obs !== e_r) begin errors++; $display("FAIL rstmid_run slot %0d: got %h expected %h", s, r_obs, e_r); end
      if (s == 0) begin val_a = 4'd5; val_b = 4'd5; end
      if (s == 1) in_valid = 1'b0;
      if (s < 6) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e_r = vec(1, 0, 0, 1, 0, 0);
    for (int c = 0; c < 2 * G; c++) begin
      checks += 2;
      if (r_obs !== e_r) begin errors++; $display("FAIL rstmid_idle_rise cycle %0d: got %h expected %h", c, r_obs, e_r); end
      if (p_obs !== e_r) begin errors++; $display("FAIL rstmid_idle_pulse cycle %0d: got %h expected %h", c, p_obs, e_r); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [8:0] e_r, e_p;
    int  ta, tb;
    bit  le_obs, le_exp;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ta = -1; tb = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (m_run) begin
        e_r = vec(qa.size() < 2, on(m_slot, qa[0], 0), on(m_slot, qb[0], 0),
                  m_slot == G - 1, m_slot == 0, m_slot);
        e_p = vec(qa.size() < 2, on(m_slot, qa[0], 1), on(m_slot, qb[0], 1),
                  m_slot == G - 1, m_slot == 0, m_slot);
      end else begin
        e_r = vec(1, 0, 0, 1, 0, 0);
        e_p = e_r;
      end
      checks += 2;
      if (r_obs !== e_r) begin errors++; $display("FAIL random_rise cycle %0d: got %h expected %h", c, r_obs, e_r); end
      if (p_obs !== e_p) begin errors++; $display("FAIL random_pulse cycle %0d: got %h expected %h", c, p_obs, e_p); end
      // Downstream less-than-or-equal: channel a must fire no later than channel b.
      if (m_run) begin
        if (m_slot == 0) begin ta = -1; tb = -1; end
        if (r_a === 1'b1 && ta < 0) ta = m_slot;
        if (r_b === 1'b1 && tb < 0) tb = m_slot;
        if (m_slot == G - 1 && qa[0] < G - 1 && qb[0] < G - 1) begin
          le_obs = (ta >= 0) && (tb < 0 || ta <= tb);
          le_exp = qa[0] <= qb[0];
          checks++;
          if (le_obs !== le_exp) begin
            errors++;
            $display("FAIL random_le a=%0d b=%0d: got %b expected %b", qa[0], qb[0], le_obs, le_exp);
          end
        end
      end
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      val_a    = 4'($urandom_range(0, G - 1));
      val_b    = 4'($urandom_range(0, G - 1));
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; val_a = '0; val_b = '0;
    test_reset();
    test_rising();
    test_back_to_back();
    test_pulse();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
